// File: rtl/conv2d_window_reader.sv
// conv2d_window_reader
// Read-side feeder for the 2D convolution engine. Issues word-addressed reads
// for all weights, then for every output pixel its in-bounds window pixels
// (halo positions are skipped without a request). Responses are buffered in a
// first-word-fall-through FIFO and streamed out as valid/ready. Requests are
// credit-limited so that outstanding reads plus buffered words never exceed
// the FIFO depth, which means a response can never be dropped.
module conv2d_window_reader #(
  parameter int WT_DIM     = 3,
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              idle,
  input  logic [31:0]       fm_dim,
  input  logic [AWIDTH-1:0] wt_base_addr,
  input  logic [AWIDTH-1:0] fm_base_addr,
  output logic [AWIDTH-1:0] req_addr,
  output logic              req_valid,
  input  logic              req_ready,
  input  logic [DWIDTH-1:0] resp_data,
  input  logic              resp_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough to hold inflight + fifo_count (up to 2*FIFO_DEPTH).
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;

  localparam logic [31:0]        K_DIM    = 32'(WT_DIM);
  localparam logic [31:0]        K_LAST   = 32'(WT_DIM - 1);
  localparam logic signed [31:0] K_HALF   = 32'(WT_DIM / 2);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WT    = 2'd1,
    ST_FM    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Window counters (m row, n col) and output-pixel counters (x col, y row).
  logic [31:0] m_r;
  logic [31:0] n_r;
  logic [31:0] x_r;
  logic [31:0] y_r;

  logic [CNT_W-1:0]  inflight_r;
  logic [CNT_W-1:0]  fifo_count_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [DWIDTH-1:0] fifo_mem_r [FIFO_DEPTH];

  logic signed [31:0] idx_s;
  logic signed [31:0] idy_s;
  logic [31:0]        fm_off_s;
  logic [31:0]        wt_off_s;
  logic               halo_s;
  logic               credit_s;
  logic               fire_s;
  logic               skip_s;
  logic               step_s;
  logic               win_last_s;
  logic               pix_last_s;
  logic               push_s;
  logic               pop_s;

  // Feature-map coordinate of the current window position; negative or
  // >= fm_dim means the position lies in the zero-padding halo.
  assign idx_s    = $signed(x_r) + $signed(n_r) - K_HALF;
  assign idy_s    = $signed(y_r) + $signed(m_r) - K_HALF;
  assign halo_s   = idx_s[31] | idy_s[31] |
                    ($unsigned(idx_s) >= fm_dim) | ($unsigned(idy_s) >= fm_dim);
  assign fm_off_s = $unsigned(idy_s) * fm_dim + $unsigned(idx_s);
  assign wt_off_s = m_r * K_DIM + n_r;

  assign credit_s   = (inflight_r + fifo_count_r) < DEPTH_C;
  assign fire_s     = req_valid & req_ready;
  assign skip_s     = (state_r == ST_FM) & halo_s;
  assign step_s     = fire_s | skip_s;
  assign win_last_s = (m_r == K_LAST) && (n_r == K_LAST);
  assign pix_last_s = (x_r == fm_dim - 32'd1) && (y_r == fm_dim - 32'd1);

  // A response arriving with nothing outstanding is a protocol error: dropped.
  assign push_s    = resp_valid & (inflight_r != CNT_ZERO);
  assign out_valid = (fifo_count_r != CNT_ZERO);
  assign pop_s     = out_valid & out_ready;
  assign out_data  = fifo_mem_r[rd_ptr_r];
  assign idle      = (state_r == ST_IDLE);

  // Request valid/address: weights in WT, in-bounds window pixels in FM.
  always_comb begin
    req_valid = 1'b0;
    req_addr  = wt_base_addr + AWIDTH'(wt_off_s);
    case (state_r)
      ST_WT: begin
        req_valid = credit_s;
      end
      ST_FM: begin
        req_valid = credit_s & ~halo_s;
        req_addr  = fm_base_addr + AWIDTH'(fm_off_s);
      end
      default: begin
        req_valid = 1'b0;
      end
    endcase
  end

  // Next-state logic of the pass sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_WT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WT: begin
        if (fire_s && win_last_s) begin
          state_next_s = ST_FM;
        end else begin
          state_next_s = ST_WT;
        end
      end
      ST_FM: begin
        if (step_s && win_last_s && pix_last_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_FM;
        end
      end
      ST_DRAIN: begin
        if ((inflight_r == CNT_ZERO) && (fifo_count_r == CNT_ZERO)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Window/pixel counters: advance on a fired request or a halo skip.
  always_ff @(posedge clk) begin
    if (rst || ((state_r == ST_IDLE) && start)) begin
      m_r <= 32'd0;
      n_r <= 32'd0;
      x_r <= 32'd0;
      y_r <= 32'd0;
    end else if (step_s) begin
      if (n_r == K_LAST) begin
        n_r <= 32'd0;
        if (m_r == K_LAST) begin
          m_r <= 32'd0;
          if (state_r == ST_FM) begin
            if (x_r == fm_dim - 32'd1) begin
              x_r <= 32'd0;
              if (y_r == fm_dim - 32'd1) begin
                y_r <= 32'd0;
              end else begin
                y_r <= y_r + 32'd1;
              end
            end else begin
              x_r <= x_r + 32'd1;
            end
          end
        end else begin
          m_r <= m_r + 32'd1;
        end
      end else begin
        n_r <= n_r + 32'd1;
      end
    end
  end

  // Outstanding-read counter: up on request fire, down on accepted response.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= CNT_ZERO;
    end else begin
      case ({fire_s, push_s})
        2'b10:   inflight_r <= inflight_r + CNT_ONE;
        2'b01:   inflight_r <= inflight_r - CNT_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      fifo_count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CNT_ONE;
        2'b01:   fifo_count_r <= fifo_count_r - CNT_ONE;
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= resp_data;
    end
  end

endmodule

// File: tb/tb_conv2d_window_reader.sv
// Self-checking bench for conv2d_window_reader. A memory model answers reads
// in order after a fixed latency with data = hash(addr); the expected address
// order is rebuilt from plain nested loops over the window geometry.
module tb_conv2d_window_reader;

  localparam int K     = 3;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          idle;
  logic [31:0]   fm_dim;
  logic [AW-1:0] wt_base_addr;
  logic [AW-1:0] fm_base_addr;
  logic [AW-1:0] req_addr;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] resp_data;
  logic          resp_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  conv2d_window_reader #(
    .WT_DIM(K), .DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .fm_dim(fm_dim),
    .wt_base_addr(wt_base_addr), .fm_base_addr(fm_base_addr),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rsp_t;

  rsp_t          rsp_q[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] fired_q[$];
  logic [DW-1:0] beats_q[$];
  int cyc, lat, rr_pct, or_pct, max_out;
  int n_checks, n_pass;
  logic s_idle, s_req_valid, s_out_valid;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Expected read order: weights row-major, then per pixel its in-bounds window.
  task automatic build_exp(input int fm);
    exp_q.delete();
    for (int m = 0; m < K; m++)
      for (int n = 0; n < K; n++)
        exp_q.push_back(AW'(32'h100 + m * K + n));
    for (int y = 0; y < fm; y++)
      for (int x = 0; x < fm; x++)
        for (int m = 0; m < K; m++)
          for (int n = 0; n < K; n++) begin
            int idx, idy;
            idx = x - K / 2 + n;
            idy = y - K / 2 + m;
            if (idx >= 0 && idx < fm && idy >= 0 && idy < fm)
              exp_q.push_back(AW'(32'h200 + idy * fm + idx));
          end
  endtask

  // One clock: drive inputs at the falling edge, record what the rising edge does.
  task automatic step();
    @(negedge clk);
    req_ready = ($urandom_range(99) < rr_pct);
    out_ready = ($urandom_range(99) < or_pct);
    if (rst) begin
      resp_valid = 1'b0;
      rsp_q.delete();
    end else if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      resp_valid = 1'b1;
      resp_data  = memf(rsp_q[0].addr);
      void'(rsp_q.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = $urandom;
    end
    s_idle      = idle;
    s_req_valid = req_valid;
    s_out_valid = out_valid;
    if (!rst) begin
      if (req_valid && req_ready) begin
        fired_q.push_back(req_addr);
        rsp_q.push_back('{addr: req_addr, due: cyc + lat});
      end
      if (out_valid && out_ready) beats_q.push_back(out_data);
      if (fired_q.size() - beats_q.size() > max_out)
        max_out = fired_q.size() - beats_q.size();
    end
    cyc++;
  endtask

  task automatic kick(input int fm);
    fm_dim = fm;
    build_exp(fm);
    fired_q.delete();
    beats_q.delete();
    rsp_q.delete();
    max_out = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (s_idle) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rr_pct = 0; or_pct = 0; lat = 1;
    fm_dim = 32'd3; wt_base_addr = 32'h100; fm_base_addr = 32'h200;
    resp_valid = 1'b0; resp_data = '0; req_ready = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_checks++; if (s_idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", s_idle); else n_pass++;
    n_checks++; if (s_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", s_req_valid); else n_pass++;
    n_checks++; if (s_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", s_out_valid); else n_pass++;
  endtask

  task automatic test_stray_resp();
    @(negedge clk);
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    resp_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stray_resp_out_valid: got %b want 0", out_valid); else n_pass++;
    step();
    n_checks++; if (s_out_valid !== 1'b0) $display("FAIL stray_resp_later: got %b want 0", s_out_valid); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok, bad;
    rr_pct = 100; or_pct = 100; lat = 1;
    kick(3);
    run_to_idle(2000, ok);
    n_checks++; if (!ok) $display("FAIL basic_timeout: idle not reached"); else n_pass++;
    n_checks++; if (fired_q.size() !== 58) $display("FAIL basic_req_count: got %0d want 58", fired_q.size()); else n_pass++;
    for (int i = 0; i < 9 && i < fired_q.size(); i++) begin
      n_checks++;
      if (fired_q[i] !== AW'(32'h100 + i)) $display("FAIL basic_wt_addr[%0d]: got %h want %h", i, fired_q[i], 32'h100 + i); else n_pass++;
    end
    begin
      logic [AW-1:0] px[4];
      px = '{32'h200, 32'h201, 32'h203, 32'h204};
      for (int i = 0; i < 4 && 9 + i < fired_q.size(); i++) begin
        n_checks++;
        if (fired_q[9 + i] !== px[i]) $display("FAIL basic_px00_addr[%0d]: got %h want %h", i, fired_q[9 + i], px[i]); else n_pass++;
      end
    end
    bad = 1'b0;
    for (int i = 0; i < exp_q.size() && i < fired_q.size() && !bad; i++) begin
      n_checks++;
      if (fired_q[i] !== exp_q[i]) begin $display("FAIL basic_addr_seq[%0d]: got %h want %h", i, fired_q[i], exp_q[i]); bad = 1'b1; end else n_pass++;
    end
    n_checks++; if (beats_q.size() !== 58) $display("FAIL basic_beat_count: got %0d want 58", beats_q.size()); else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < exp_q.size() && i < beats_q.size() && !bad; i++) begin
      n_checks++;
      if (beats_q[i] !== memf(exp_q[i])) begin $display("FAIL basic_data_seq[%0d]: got %h want %h", i, beats_q[i], memf(exp_q[i])); bad = 1'b1; end else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok, bad;
    rr_pct = 100; or_pct = 0; lat = 1;
    kick(3);
    repeat (40) step();
    n_checks++; if (fired_q.size() !== 4) $display("FAIL bp_stalled_reqs: got %0d want 4", fired_q.size()); else n_pass++;
    n_checks++; if (s_req_valid !== 1'b0) $display("FAIL bp_req_valid: got %b want 0", s_req_valid); else n_pass++;
    n_checks++; if (s_out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", s_out_valid); else n_pass++;
    or_pct = 100;
    run_to_idle(2000, ok);
    n_checks++; if (!ok) $display("FAIL bp_timeout: idle not reached"); else n_pass++;
    n_checks++; if (fired_q.size() !== exp_q.size()) $display("FAIL bp_req_count: got %0d want %0d", fired_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (beats_q.size() !== 58) $display("FAIL bp_beat_count: got %0d want 58", beats_q.size()); else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < exp_q.size() && i < beats_q.size() && !bad; i++) begin
      n_checks++;
      if (beats_q[i] !== memf(exp_q[i])) begin $display("FAIL bp_data_seq[%0d]: got %h want %h", i, beats_q[i], memf(exp_q[i])); bad = 1'b1; end else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok, bad;
    int fm;
    for (int t = 0; t < 3; t++) begin
      rr_pct = 50; or_pct = 50; lat = 3;
      fm = $urandom_range(2, 6);
      kick(fm);
      run_to_idle(20000, ok);
      n_checks++; if (!ok) $display("FAIL rand_timeout: fm=%0d idle not reached", fm); else n_pass++;
      n_checks++; if (fired_q.size() !== exp_q.size()) $display("FAIL rand_req_count: fm=%0d got %0d want %0d", fm, fired_q.size(), exp_q.size()); else n_pass++;
      n_checks++; if (beats_q.size() !== exp_q.size()) $display("FAIL rand_beat_count: fm=%0d got %0d want %0d", fm, beats_q.size(), exp_q.size()); else n_pass++;
      n_checks++; if (max_out > DEPTH) $display("FAIL rand_credit: outstanding reached %0d want <= %0d", max_out, DEPTH); else n_pass++;
      bad = 1'b0;
      for (int i = 0; i < exp_q.size() && i < fired_q.size() && !bad; i++) begin
        n_checks++;
        if (fired_q[i] !== exp_q[i]) begin $display("FAIL rand_addr_seq[%0d]: got %h want %h", i, fired_q[i], exp_q[i]); bad = 1'b1; end else n_pass++;
      end
      bad = 1'b0;
      for (int i = 0; i < exp_q.size() && i < beats_q.size() && !bad; i++) begin
        n_checks++;
        if (beats_q[i] !== memf(exp_q[i])) begin $display("FAIL rand_data_seq[%0d]: got %h want %h", i, beats_q[i], memf(exp_q[i])); bad = 1'b1; end else n_pass++;
      end
    end
  endtask

  task automatic test_fm1();
    bit ok, bad;
    rr_pct = 100; or_pct = 100; lat = 1;
    kick(1);
    run_to_idle(500, ok);
    n_checks++; if (!ok) $display("FAIL fm1_timeout: idle not reached"); else n_pass++;
    n_checks++; if (fired_q.size() !== 10) $display("FAIL fm1_req_count: got %0d want 10", fired_q.size()); else n_pass++;
    n_checks++; if (fired_q.size() > 9 && fired_q[9] !== 32'h200) $display("FAIL fm1_px_addr: got %h want 200", fired_q[9]); else n_pass++;
    n_checks++; if (beats_q.size() !== 10) $display("FAIL fm1_beat_count: got %0d want 10", beats_q.size()); else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < exp_q.size() && i < beats_q.size() && !bad; i++) begin
      n_checks++;
      if (beats_q[i] !== memf(exp_q[i])) begin $display("FAIL fm1_data_seq[%0d]: got %h want %h", i, beats_q[i], memf(exp_q[i])); bad = 1'b1; end else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    bit ok, bad;
    rr_pct = 100; or_pct = 100; lat = 2;
    kick(3);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (fired_q.size() >= 11) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL rstmid_reach_fm: fired %0d want >= 11", fired_q.size()); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++; if (s_idle !== 1'b1) $display("FAIL rstmid_idle: got %b want 1", s_idle); else n_pass++;
    n_checks++; if (s_out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", s_out_valid); else n_pass++;
    n_checks++; if (s_req_valid !== 1'b0) $display("FAIL rstmid_req_valid: got %b want 0", s_req_valid); else n_pass++;
    kick(3);
    run_to_idle(2000, ok);
    n_checks++; if (!ok) $display("FAIL rstmid_timeout: idle not reached"); else n_pass++;
    n_checks++; if (fired_q.size() !== 58) $display("FAIL rstmid_req_count: got %0d want 58", fired_q.size()); else n_pass++;
    n_checks++; if (beats_q.size() !== 58) $display("FAIL rstmid_beat_count: got %0d want 58", beats_q.size()); else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < exp_q.size() && i < fired_q.size() && !bad; i++) begin
      n_checks++;
      if (fired_q[i] !== exp_q[i]) begin $display("FAIL rstmid_addr_seq[%0d]: got %h want %h", i, fired_q[i], exp_q[i]); bad = 1'b1; end else n_pass++;
    end
  endtask

  task automatic test_start_again();
    bit ok, bad;
    rr_pct = 100; or_pct = 100; lat = 1;
    kick(3);
    repeat (20) step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_idle(2000, ok);
    n_checks++; if (!ok) $display("FAIL restart_timeout: idle not reached"); else n_pass++;
    n_checks++; if (fired_q.size() !== 58) $display("FAIL restart_req_count: got %0d want 58", fired_q.size()); else n_pass++;
    n_checks++; if (beats_q.size() !== 58) $display("FAIL restart_beat_count: got %0d want 58", beats_q.size()); else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < exp_q.size() && i < fired_q.size() && !bad; i++) begin
      n_checks++;
      if (fired_q[i] !== exp_q[i]) begin $display("FAIL restart_addr_seq[%0d]: got %h want %h", i, fired_q[i], exp_q[i]); bad = 1'b1; end else n_pass++;
    end
    repeat (10) step();
    n_checks++; if (s_idle !== 1'b1) $display("FAIL restart_stays_idle: got %b want 1", s_idle); else n_pass++;
    n_checks++; if (fired_q.size() !== 58) $display("FAIL restart_no_extra_reqs: got %0d want 58", fired_q.size()); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; max_out = 0;
    test_reset();
    test_stray_resp();
    test_basic();
    test_backpressure();
    test_random();
    test_fm1();
    test_rst_mid();
    test_start_again();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
